mux_arb: RTL and testbench

Parametrised N-input, WIDTH-bit registered selector with a valid/ready handshake on every channel. It is the datapath source-select stage: it picks one of N producers (ALU, memory, immediate, ...) per cycle and registers the word towards the register-file write port. Selection is either explicit (driven by the control unit) or round-robin (fair arbitration between requesters). Output is held stable under back-pressure.

---
 rtl/mux_pkg.sv | 12 +
 rtl/mux_arb_rr_arbiter.sv | 48 ++++
 rtl/mux_arb.sv | 93 +++++++++
 tb/tb_mux_arb.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the mux_arb source-select stage.
package mux_pkg;

    localparam int MODE_EXPLICIT = 0;
    localparam int MODE_RR       = 1;

    // Width of a channel index for n channels; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
// The priority pointer moves past the winner only when a grant is consumed.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N = 4,
    localparam int PW = sel_width(N)
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;
    logic          found;

    // Scan ptr, ptr+1, ..., wrapping modulo N; the first requester wins.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        ptr_next = ptr_reg;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = int'(ptr_reg) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[PW'(idx)]) begin
                grant[PW'(idx)] = 1'b1;
                found           = 1'b1;
                ptr_next        = (idx == N - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    // Priority rotates only on a granted transfer; idle cycles keep it.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            ptr_reg <= '0;
        end else if (advance && found) begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/mux_arb.sv
// N-input registered source selector with valid/ready on every channel.
// Selection is explicit (sel) or round-robin; the output holds under back-pressure.
module mux_arb
    import mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int MODE  = MODE_EXPLICIT,
    localparam int SW   = sel_width(N)
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SW-1:0]        sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SW-1:0]        out_src,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic             load;
    logic             load_ok;
    logic [N-1:0]     grant;
    logic [SW-1:0]    grant_idx;
    logic [WIDTH-1:0] mux_data;
    logic [WIDTH-1:0] masked [N];

    // Output register is empty or draining; reset suppresses any acceptance.
    assign load    = !out_valid || out_ready;
    assign load_ok = load && !reset;

    genvar gi;
    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [N-1:0] rr_grant;
            logic         unused_sel;

            assign unused_sel = ^sel;

            rr_arbiter #(.N(N)) u_arb (
                .CLK     (CLK),
                .reset   (reset),
                .req     (in_valid),
                .advance (load_ok),
                .grant   (rr_grant)
            );

            assign grant = rr_grant & {N{load_ok}};
        end else begin : g_explicit
            // sel values at or above N match no channel, so they grant nothing.
            for (gi = 0; gi < N; gi++) begin : g_sel
                assign grant[gi] = load_ok && in_valid[gi] && (sel == SW'(gi));
            end
        end

        // AND-OR data mux over the one-hot grant.
        for (gi = 0; gi < N; gi++) begin : g_mask
            assign masked[gi] = {WIDTH{grant[gi]}} & in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign in_ready = grant;

    // Collapse the masked channels and encode the winning index.
    always_comb begin
        mux_data  = '0;
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            mux_data = mux_data | masked[i];
            if (grant[i]) begin
                grant_idx = SW'(i);
            end
        end
    end

    // Load on grant, empty on an idle drain, otherwise hold.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_src   <= '0;
            out_valid <= 1'b0;
        end else if (|grant) begin
            out_data  <= mux_data;
            out_src   <= grant_idx;
            out_valid <= 1'b1;
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb.sv
// Directed bench for mux_arb: explicit N=4, round-robin N=4, explicit N=3.
module tb_mux_arb;
    import mux_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Explicit-select instance, N = 4
    logic        e_rst = 1'b1;
    logic [63:0] e_in_data = '0;
    logic [3:0]  e_in_valid = '0;
    logic [3:0]  e_in_ready;
    logic [1:0]  e_sel = '0;
    logic [15:0] e_out_data;
    logic [1:0]  e_out_src;
    logic        e_out_valid;
    logic        e_out_ready = 1'b1;

    // Round-robin instance, N = 4
    logic        r_rst = 1'b1;
    logic [63:0] r_in_data = '0;
    logic [3:0]  r_in_valid = '0;
    logic [3:0]  r_in_ready;
    logic [1:0]  r_sel = '0;
    logic [15:0] r_out_data;
    logic [1:0]  r_out_src;
    logic        r_out_valid;
    logic        r_out_ready = 1'b1;

    // Explicit-select instance, N = 3
    logic        t_rst = 1'b1;
    logic [47:0] t_in_data = '0;
    logic [2:0]  t_in_valid = '0;
    logic [2:0]  t_in_ready;
    logic [1:0]  t_sel = '0;
    logic [15:0] t_out_data;
    logic [1:0]  t_out_src;
    logic        t_out_valid;
    logic        t_out_ready = 1'b1;

    mux_arb #(.WIDTH(16), .N(4), .MODE(MODE_EXPLICIT)) u_exp (
        .CLK(clk), .reset(e_rst), .in_data(e_in_data), .in_valid(e_in_valid),
        .in_ready(e_in_ready), .sel(e_sel), .out_data(e_out_data),
        .out_src(e_out_src), .out_valid(e_out_valid), .out_ready(e_out_ready));

    mux_arb #(.WIDTH(16), .N(4), .MODE(MODE_RR)) u_rr (
        .CLK(clk), .reset(r_rst), .in_data(r_in_data), .in_valid(r_in_valid),
        .in_ready(r_in_ready), .sel(r_sel), .out_data(r_out_data),
        .out_src(r_out_src), .out_valid(r_out_valid), .out_ready(r_out_ready));

    mux_arb #(.WIDTH(16), .N(3), .MODE(MODE_EXPLICIT)) u_exp3 (
        .CLK(clk), .reset(t_rst), .in_data(t_in_data), .in_valid(t_in_valid),
        .in_ready(t_in_ready), .sel(t_sel), .out_data(t_out_data),
        .out_src(t_out_src), .out_valid(t_out_valid), .out_ready(t_out_ready));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        e_in_data  = {16'h3333, 16'hBEEF, 16'h1111, 16'h0A0A};
        e_in_valid = 4'hF;
        e_sel      = 2'd2;
        e_out_ready = 1'b1;
        tick();
        tick();
        checks++; if (e_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", e_out_valid); end
        checks++; if (e_in_ready !== 4'h0) begin failures++; $display("FAIL reset_in_ready got=%h want=0", e_in_ready); end
        checks++; if (e_out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h want=0000", e_out_data); end
        checks++; if (e_out_src !== 2'd0) begin failures++; $display("FAIL reset_out_src got=%0d want=0", e_out_src); end
        e_rst = 1'b0;
        #1;
        checks++; if (e_in_ready !== 4'b0100) begin failures++; $display("FAIL release_in_ready got=%b want=0100", e_in_ready); end
        tick();
        checks++; if (e_out_data !== 16'hBEEF) begin failures++; $display("FAIL first_data got=%h want=beef", e_out_data); end
        checks++; if (e_out_src !== 2'd2) begin failures++; $display("FAIL first_src got=%0d want=2", e_out_src); end
        checks++; if (e_out_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b want=1", e_out_valid); end
        $display("test_reset done: out_data=%h out_src=%0d", e_out_data, e_out_src);
    endtask

    task automatic test_back_pressure;
        e_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            e_sel = 2'(k);
            e_in_data[47:32] = 16'hDEAD + 16'(k);
            #1;
            checks++; if (e_in_ready !== 4'h0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%h want=0", k, e_in_ready); end
            tick();
            checks++; if (e_out_data !== 16'hBEEF || e_out_src !== 2'd2 || e_out_valid !== 1'b1)
                begin failures++; $display("FAIL bp_hold[%0d] got=%h/%0d/%b want=beef/2/1", k, e_out_data, e_out_src, e_out_valid); end
            $display("back_pressure cycle %0d: out_data=%h", k, e_out_data);
        end
        e_sel = 2'd1;
        e_out_ready = 1'b1;
        #1;
        checks++; if (e_in_ready !== 4'b0010) begin failures++; $display("FAIL drain_in_ready got=%b want=0010", e_in_ready); end
        tick();
        checks++; if (e_out_data !== 16'h1111 || e_out_src !== 2'd1 || e_out_valid !== 1'b1)
            begin failures++; $display("FAIL refill got=%h/%0d/%b want=1111/1/1", e_out_data, e_out_src, e_out_valid); end
        $display("refill: out_data=%h out_src=%0d", e_out_data, e_out_src);
    endtask

    task automatic test_back_to_back;
        e_sel = 2'd3;
        tick();
        checks++; if (e_out_data !== 16'h3333 || e_out_src !== 2'd3 || e_out_valid !== 1'b1)
            begin failures++; $display("FAIL b2b got=%h/%0d/%b want=3333/3/1", e_out_data, e_out_src, e_out_valid); end
        $display("back_to_back: out_data=%h out_src=%0d", e_out_data, e_out_src);
        e_in_valid = 4'h0;
        tick();
        checks++; if (e_out_valid !== 1'b0 || e_out_data !== 16'h3333 || e_out_src !== 2'd3)
            begin failures++; $display("FAIL idle_drain got=%h/%0d/%b want=3333/3/0", e_out_data, e_out_src, e_out_valid); end
        $display("idle_drain: out_valid=%b", e_out_valid);
    endtask

    task automatic test_rr_fairness;
        r_in_data   = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        r_out_ready = 1'b1;
        r_in_valid  = 4'hF;
        r_rst       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (r_in_ready !== 4'(1 << (i % 4))) begin failures++; $display("FAIL rr_ready[%0d] got=%b want=%b", i, r_in_ready, 4'(1 << (i % 4))); end
            tick();
            checks++; if (r_out_src !== 2'(i % 4) || r_out_data !== 16'hA000 + 16'(i % 4) || r_out_valid !== 1'b1)
                begin failures++; $display("FAIL rr_out[%0d] got=%h/%0d/%b want=%h/%0d/1", i, r_out_data, r_out_src, r_out_valid, 16'hA000 + 16'(i % 4), i % 4); end
            $display("rr cycle %0d: out_src=%0d out_data=%h", i, r_out_src, r_out_data);
        end
    endtask

    task automatic test_rr_sparse;
        // Grant channel 2 alone so the pointer lands on 3.
        r_in_valid = 4'b0100;
        tick();
        checks++; if (r_out_src !== 2'd2) begin failures++; $display("FAIL sparse_setup got=%0d want=2", r_out_src); end
        r_in_valid = 4'b0110;
        #1;
        checks++; if (r_in_ready !== 4'b0010) begin failures++; $display("FAIL sparse_wrap_ready got=%b want=0010", r_in_ready); end
        tick();
        checks++; if (r_out_src !== 2'd1 || r_out_data !== 16'hA001) begin failures++; $display("FAIL sparse_first got=%0d/%h want=1/a001", r_out_src, r_out_data); end
        tick();
        checks++; if (r_out_src !== 2'd2 || r_out_data !== 16'hA002) begin failures++; $display("FAIL sparse_second got=%0d/%h want=2/a002", r_out_src, r_out_data); end
        $display("sparse: grants 1 then 2");
        // Idle cycles must not rotate the pointer away from 3.
        r_in_valid = 4'h0;
        tick();
        tick();
        r_in_valid = 4'hF;
        #1;
        checks++; if (r_in_ready !== 4'b1000) begin failures++; $display("FAIL idle_no_rotate got=%b want=1000", r_in_ready); end
        tick();
        checks++; if (r_out_src !== 2'd3) begin failures++; $display("FAIL ptr3_grant got=%0d want=3", r_out_src); end
        $display("idle hold: out_src=%0d", r_out_src);
    endtask

    task automatic test_async_reset;
        // Pointer now 0; grant channel 1 alone so the pointer becomes 2.
        r_in_valid = 4'b0010;
        tick();
        checks++; if (r_out_src !== 2'd1 || r_out_valid !== 1'b1) begin failures++; $display("FAIL pre_reset got=%0d/%b want=1/1", r_out_src, r_out_valid); end
        r_in_valid  = 4'hF;
        r_out_ready = 1'b0;
        #2;
        r_rst = 1'b1;
        #1;
        checks++; if (r_out_valid !== 1'b0) begin failures++; $display("FAIL async_valid got=%b want=0", r_out_valid); end
        checks++; if (r_out_data !== 16'h0) begin failures++; $display("FAIL async_data got=%h want=0000", r_out_data); end
        r_out_ready = 1'b1;
        #1;
        checks++; if (r_in_ready !== 4'h0) begin failures++; $display("FAIL ready_in_reset got=%b want=0000", r_in_ready); end
        r_rst = 1'b0;
        #1;
        checks++; if (r_in_ready !== 4'b0001) begin failures++; $display("FAIL ptr_after_reset got=%b want=0001", r_in_ready); end
        tick();
        checks++; if (r_out_src !== 2'd0 || r_out_data !== 16'hA000) begin failures++; $display("FAIL post_reset_grant got=%0d/%h want=0/a000", r_out_src, r_out_data); end
        $display("async reset: next grant out_src=%0d", r_out_src);
    endtask

    task automatic test_explicit_range;
        t_in_data   = {16'h0102, 16'h0101, 16'h0100};
        t_in_valid  = 3'b111;
        t_sel       = 2'd2;
        t_out_ready = 1'b1;
        t_rst       = 1'b0;
        tick();
        checks++; if (t_out_src !== 2'd2 || t_out_data !== 16'h0102 || t_out_valid !== 1'b1)
            begin failures++; $display("FAIL n3_load got=%h/%0d/%b want=0102/2/1", t_out_data, t_out_src, t_out_valid); end
        t_sel = 2'd3;
        #1;
        checks++; if (t_in_ready !== 3'b000) begin failures++; $display("FAIL sel_oob_ready got=%b want=000", t_in_ready); end
        tick();
        checks++; if (t_out_valid !== 1'b0 || t_out_data !== 16'h0102 || t_out_src !== 2'd2)
            begin failures++; $display("FAIL sel_oob_drain got=%h/%0d/%b want=0102/2/0", t_out_data, t_out_src, t_out_valid); end
        $display("sel out of range: out_valid=%b", t_out_valid);
        t_sel = 2'd0;
        tick();
        checks++; if (t_out_src !== 2'd0 || t_out_data !== 16'h0100 || t_out_valid !== 1'b1)
            begin failures++; $display("FAIL n3_ch0 got=%h/%0d/%b want=0100/0/1", t_out_data, t_out_src, t_out_valid); end
        t_sel      = 2'd1;
        t_in_valid = 3'b101;
        #1;
        checks++; if (t_in_ready !== 3'b000) begin failures++; $display("FAIL sel_invalid_ready got=%b want=000", t_in_ready); end
        tick();
        checks++; if (t_out_valid !== 1'b0 || t_out_data !== 16'h0100) begin failures++; $display("FAIL sel_invalid_drain got=%h/%b want=0100/0", t_out_data, t_out_valid); end
        $display("sel invalid channel: out_valid=%b", t_out_valid);
    endtask

    initial begin
        test_reset();
        test_back_pressure();
        test_back_to_back();
        test_rr_fairness();
        test_rr_sparse();
        test_async_reset();
        test_explicit_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
